// File: rtl/mem_pkg.sv
// Shared types and helpers for the RV32I data memory: access size codes,
// controller states, lane mask and fault decoding.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RESP
  } mem_state_e;

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    logic [3:0] mask;
    case (funct3)
      MEM_B, MEM_BU: mask = 4'b0001 << offset;
      MEM_H, MEM_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
      MEM_W:         mask = 4'b1111;
      default:       mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Unsigned sizes are load-only, so a store with funct3[2] set faults too.
  function automatic logic access_fault(input logic we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic fault;
    case (funct3)
      MEM_B:   fault = 1'b0;
      MEM_H:   fault = offset[0];
      MEM_W:   fault = |offset;
      MEM_BU:  fault = we;
      MEM_HU:  fault = we | offset[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus of the data memory; the core side is the master.
interface data_mem_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic        err;

  modport master (
    output req_valid, req_we, funct3, addr, write_data,
    input  req_ready, rsp_valid, read_data, err
  );

  modport slave (
    input  req_valid, req_we, funct3, addr, write_data,
    output req_ready, rsp_valid, read_data, err
  );

endinterface

// File: rtl/data_mem_load_align.sv
// Load result formatting: moves the addressed lane(s) to the LSBs and
// applies sign or zero extension according to the size code.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      MEM_B:   result = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  result = {24'h000000, shifted[7:0]};
      MEM_H:   result = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  result = {16'h0000, shifted[15:0]};
      MEM_W:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with one access per cycle, a one-cycle
// registered response, misalignment faults and an optional zero-fill after reset.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int IDXW           = $clog2(DEPTH_WORDS)
) (
  input logic       CLK,
  input logic       RST_N,
  data_mem_if.slave bus
);

  mem_state_e      state, state_next;
  logic [IDXW-1:0] clear_idx;
  logic [IDXW-1:0] word_idx;
  logic [1:0]      offset;
  logic            accept;
  logic            fault;
  logic            clearing;
  logic            store_en;
  logic            load_en;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     rd_word;
  logic [31:0]     aligned;
  logic            rsp_active;

  logic            rsp_err;
  logic            rsp_load;
  logic [2:0]      rsp_funct3;
  logic [1:0]      rsp_offset;

  assign word_idx = bus.addr[IDXW+1:2];
  assign offset   = bus.addr[1:0];
  assign fault    = access_fault(bus.req_we, bus.funct3, offset);
  assign be       = byte_enable(bus.funct3, offset);

  // Ready is forced low in the reset cycle so nothing is accepted then.
  assign bus.req_ready = RST_N && (state == IDLE || state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  assign clearing      = RST_N && (state == CLEAR);
  assign store_en      = accept && bus.req_we && !fault;
  assign load_en       = accept && !bus.req_we;

  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   wdata_rep = {4{bus.write_data[7:0]}};
      2'b01:   wdata_rep = {2{bus.write_data[15:0]}};
      default: wdata_rep = bus.write_data;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clear_idx == '1) state_next = IDLE;
      IDLE:    if (accept) state_next = RESP;
      RESP:    state_next = accept ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      clear_idx  <= '0;
      rsp_err    <= 1'b0;
      rsp_load   <= 1'b0;
      rsp_funct3 <= 3'b000;
      rsp_offset <= 2'b00;
    end else begin
      if (state == CLEAR) begin
        clear_idx <= clear_idx + IDXW'(1);
      end
      if (accept) begin
        rsp_err    <= fault;
        rsp_load   <= !bus.req_we;
        rsp_funct3 <= bus.funct3;
        rsp_offset <= offset;
      end
    end
  end

  // One RAM per byte lane with a registered read port, so each maps onto
  // a plain block RAM; the array itself is only ever zeroed by CLEAR.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] ram [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge CLK) begin
      if (clearing) begin
        ram[clear_idx] <= 8'h00;
      end else if (store_en && be[g]) begin
        ram[word_idx] <= wdata_rep[8*g +: 8];
      end
      if (load_en) begin
        rd_q <= ram[word_idx];
      end
    end
  end

  assign rd_word = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};

  load_align u_load_align (
    .word   (rd_word),
    .funct3 (rsp_funct3),
    .offset (rsp_offset),
    .result (aligned)
  );

  assign rsp_active    = RST_N && (state == RESP);
  assign bus.rsp_valid = rsp_active;
  assign bus.err       = rsp_active && rsp_err;
  assign bus.read_data = (rsp_active && rsp_load && !rsp_err) ? aligned : '0;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words, a power of two, minimum 4.
REQ-002 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning the memory is zero-filled after reset when 1.
REQ-003 The block SHALL have parameter IDXW, default $clog2(DEPTH_WORDS), meaning the word-index width; it is derived and is not overridden.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  access request present.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 addr  input  32  byte address.
REQ-010 write_data  input  32  store data, with the value in the LSBs.
REQ-011 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-012 rsp_valid  output  1  response present for one cycle.
REQ-013 read_data  output  32  extended load result; 0 when not a load response.
REQ-014 err  output  1  accompanies rsp_valid; access faulted.

Function
REQ-015 FSM states SHALL be CLEAR, IDLE and RESP.
REQ-016 After reset, the FSM SHALL enter CLEAR when CLEAR_ON_RESET=1, else IDLE.
REQ-017 In CLEAR, the block SHALL write 0 to one word per cycle from index 0 to DEPTH_WORDS-1, then enter IDLE; the clear takes DEPTH_WORDS cycles.
REQ-018 req_ready SHALL be 1 only in IDLE and RESP, and 0 in CLEAR.
REQ-019 The word index SHALL be addr[IDXW+1:2]; upper address bits SHALL be ignored, so addresses wrap.
REQ-020 A fault SHALL be raised for: an illegal funct3 (011, 110, 111); a halfword access with addr[0]=1; a word access with addr[1:0]!=0; a store with funct3 of 1xx.
REQ-021 An accepted store without a fault SHALL write only the addressed byte lanes on the acceptance edge; the other lanes SHALL be unchanged.
REQ-022 An accepted access SHALL produce rsp_valid exactly one cycle later, for loads and for stores, and the FSM SHALL be in RESP during that cycle.
REQ-023 A load response SHALL carry the addressed lane(s) shifted to the LSBs: B and H sign-extended, BU and HU zero-extended, W unmodified.
REQ-024 A faulted access SHALL not modify memory, and its response SHALL show err=1 and read_data=0.
REQ-025 In RESP, a new request SHALL be accepted, giving back-to-back throughput of one access per cycle.
REQ-026 Without a new acceptance, the FSM SHALL go from RESP to IDLE.
REQ-027 A load accepted in the cycle after a store to the same word SHALL return the post-store value.
REQ-028 read_data SHALL come from a registered read (synchronous RAM inference), not from asynchronous array indexing.
REQ-029 The memory array SHALL have no reset other than the CLEAR sequence.

Reset
REQ-030 When RST_N=0 at a rising CLK edge: rsp_valid=0, err=0, read_data=0, req_ready=0, and the clear counter is set to 0.
REQ-031 Reset asserted mid-CLEAR SHALL restart CLEAR from index 0.
REQ-032 Reset asserted during RESP SHALL drop the pending response, with no rsp_valid afterwards.
REQ-033 A store presented in the reset cycle SHALL not be written.

Structure
REQ-034 Package mem_pkg SHALL hold: the funct3 enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU); the FSM state enum; and a function giving the byte-enable mask from funct3 and addr[1:0].
REQ-035 Sub-module load_align (combinational) SHALL perform the lane select and the sign/zero extension; data_mem instantiates it once.
REQ-036 The memory array SHALL be coded as 4 byte-lane arrays or as a byte-enabled single array, so that it is inferable as block RAM.

Verification
REQ-037 Clear: DEPTH_WORDS=16, CLEAR_ON_RESET=1, after RST_N deasserts -> req_ready=0 for exactly 16 cycles; then a LW at addr 0x3C returns 0x00000000.
REQ-038 Sizes: SW 0x8000_80F0 @0x10, then LB @0x10 -> 0xFFFFFFF0; LBU @0x10 -> 0x000000F0; LH @0x12 -> 0xFFFF8000; LHU @0x12 -> 0x00008000; LW @0x10 -> 0x800080F0.
REQ-039 Byte store: SW 0x11223344 @0x20, SB 0xAA @0x21, LW @0x20 -> 0x1122AA44; an SH 0xBEEF @0x22 followed by LW -> 0xBEEFAA44.
REQ-040 Faults: LW @0x06, SH @0x03 and funct3=011 -> each gives rsp_valid with err=1 and read_data=0; a following LW @0x04 shows the memory unchanged.
REQ-041 Back-to-back: an SW 0xCAFEF00D @0x08 accepted at cycle n and an LW @0x08 at cycle n+1 -> rsp_valid in cycles n+1 and n+2; the load returns 0xCAFEF00D.
REQ-042 Reset mid-operation: RST_N pulsed at clear index 7, and again during RESP -> the clear restarts at index 0, there is no stray rsp_valid, and all outputs are 0 in the reset cycle.
